// File: rtl/rr_packet_aggregator.sv
// rr_packet_aggregator
// Merges NUM_CH engine word streams into one output stream. Arbitration is
// round-robin at packet granularity. A packet is a header word plus a payload
// whose length sits in the header's low LEN_W bits. Once a channel holds the
// grant, its whole packet is forwarded before any other channel is considered.

module rr_packet_aggregator #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic [15:0]              pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]  remaining;

  logic [DATA_W-1:0] ch_word [NUM_CH];
  logic [DATA_W-1:0] grant_word;
  logic [LEN_W-1:0]  hdr_len;
  logic              load_en;
  logic              in_packet;
  logic              accept;
  logic [CH_W-1:0]   next_ptr;
  logic [CH_W-1:0]   arb_sel;
  logic [CH_W-1:0]   arb_cand;
  logic              arb_found;

  // Adds an offset to a channel index, wrapping at NUM_CH. The wrap is
  // explicit so that non-power-of-two channel counts stay inside 0..NUM_CH-1.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Splits the flat input bus into one word per channel.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign ch_word[k] = in_data[k*DATA_W +: DATA_W];
  end

  // The output register can take a new word when it is empty or being drained.
  assign load_en    = !out_valid || out_ready;
  assign in_packet  = (state == HEADER) || (state == PAYLOAD);
  assign grant_word = ch_word[grant];
  assign hdr_len    = grant_word[LEN_W-1:0];
  assign accept     = in_packet && load_en && in_valid[grant];
  assign next_ptr   = wrap_add(grant, 1);

  // Only the granted channel sees ready, and only while a packet is open.
  always_comb begin
    in_ready = '0;
    if (in_packet && load_en) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Round-robin search starting at rr_ptr. The first valid channel wins.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_cand = wrap_add(rr_ptr, i);
      if (!arb_found && in_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  // Packet FSM together with the registered output stage and packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      if (out_valid && out_ready && out_last) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end

      // The word is drained. A load below overrides this in the same cycle.
      if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_sel;
            state <= HEADER;
          end
        end

        HEADER: begin
          if (accept) begin
            out_data  <= grant_word;
            out_valid <= 1'b1;
            out_ch    <= grant;
            remaining <= hdr_len;
            if (hdr_len == '0) begin
              out_last <= 1'b1;
              rr_ptr   <= next_ptr;
              state    <= IDLE;
            end else begin
              out_last <= 1'b0;
              state    <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (accept) begin
            out_data  <= grant_word;
            out_valid <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            out_last  <= (remaining == LEN_W'(1));
            if (remaining == LEN_W'(1)) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_packet_aggregator.md
Name: rr_packet_aggregator

Overview:
- Parametrised successor to the two-engine aggregator.
- Merges NUM_CH upstream engine word streams into one output stream using round-robin packet arbitration.
- Each packet starts with a header word whose low LEN_W bits give the payload length in words; the whole packet is forwarded before another channel is granted.
- Sits between the processing engines and the downstream packer, with valid/ready handshakes on every interface.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).
- DATA_W, 32, word width of inputs and output.
- LEN_W, 8, width of the header length field; payload length range is 0..2^LEN_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel word valid.
- in_data  in  NUM_CH*DATA_W  per-channel word; channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel word accept.
- out_data  out  DATA_W  aggregated word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_ch  out  CH_W  source channel of the current word.
- out_last  out  1  marks the final word of a packet.
- pkt_cnt  out  16  count of completed packets, wraps.

Behaviour:
- Reset (async, any time): state=IDLE, grant=0, rr_ptr=0, remaining=0. Outputs: in_ready=0, out_valid=0, out_data=0, out_ch=0, out_last=0, pkt_cnt=0. A partial packet is discarded and no trailing words are emitted.
- Transfer rule: a word moves when valid&&ready on the same edge. out_data, out_ch and out_last are held stable while out_valid&&!out_ready.
- load_en = !out_valid || out_ready. in_ready[grant] = load_en in HEADER and PAYLOAD; in_ready is 0 for all other channels and in every state other than HEADER/PAYLOAD.
- IDLE:
  - If any in_valid, grant <= first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... mod NUM_CH; go to HEADER.
  - Otherwise stay in IDLE.
- HEADER, on accept:
  - out_data <= word, out_valid <= 1, out_ch <= grant, remaining <= word[LEN_W-1:0].
  - If length==0: out_last <= 1, rr_ptr <= (grant+1) mod NUM_CH, go to IDLE.
  - Else: out_last <= 0, go to PAYLOAD.
- PAYLOAD, on accept:
  - out_data <= word, out_valid <= 1, remaining <= remaining-1, out_last <= (remaining==1).
  - If remaining==1: rr_ptr <= (grant+1) mod NUM_CH, go to IDLE.
- When out_ready and no new load: out_valid <= 0 and out_last <= 0.
- Latency: a word accepted at edge N is on out_data after edge N.
- Throughput: one word per cycle within a packet. Exactly one arbitration (IDLE) cycle between packets.
- Simultaneous output drain and new load in the same cycle: the load wins and out_valid stays 1.
- Granted channel drops in_valid mid-packet: insert bubbles and hold the grant indefinitely. There is no timeout and no pre-emption.
- Non-granted channels may assert in_valid at any time; they are never accepted until granted.
- pkt_cnt increments on out_valid&&out_ready&&out_last and wraps from 0xFFFF to 0.
- A rr_ptr value outside 0..NUM_CH-1 is unreachable; arbitration wraps modulo NUM_CH.
- Length field maximum (2^LEN_W-1) is forwarded in full; remaining is LEN_W bits wide.

Test Plan:
- Reset, then ch0 sends header len=3 + words A,B,C with out_ready=1 -> out sequence hdr,A,B,C on 4 consecutive cycles; out_ch=0; out_last only on C; pkt_cnt=1.
- All 4 channels continuously valid with len=1 packets -> grant order 0,1,2,3,0; one idle cycle between packets; pkt_cnt=5 after 5 packets.
- Header len=0 on ch2 -> single output word with out_last=1, then ch3 is searched first next.
- out_ready held low 5 cycles mid-packet (len=4) -> out_data stable, in_ready[grant]=0 while the output is full, no word lost or duplicated, 5 words total.
- Async reset asserted mid-PAYLOAD (2 of 6 words sent) -> outputs clear immediately without a clock edge; the next packet starts from ch0 priority; pkt_cnt=0.
- len=255 packet on ch1 -> 256 words out, out_last on word 256, pkt_cnt increments once.
